tube_issue: RTL and testbench
=============================

# tube_issue

Issue stage directly upstream of the tube tracker. Accepts entries from a producer over a valid/ready stream, buffers them in a small FIFO, and injects one entry per cycle into the tube's input only when the entry's tag is not already in flight in the tube. It also drives a bubble (all-zero entry) when nothing can issue, and counts hazard stalls for performance monitoring.

## Interface
- DEPTH, 4: tube depth; must equal the downstream tube's DEPTH.
- FIFO_DEPTH, 4: issue buffer entries; power of two, ≥2.
- TAG_W, 5: tag width used for hazard matching.
- DATA_W, 32: payload width, carried opaquely.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous flush of buffer and issue register.
- clr_stats  in  1  synchronous clear of stall_cnt.
- in_valid  in  1  producer entry valid.
- in_ready  out  1  buffer can accept this cycle.
- in_tag  in  TAG_W  producer tag.
- in_data  in  DATA_W  producer payload.
- tube_valid  in  DEPTH  valid bit of each tube slot; bit 0 is oldest.
- tube_tag  in  DEPTH*TAG_W  tag of each tube slot; slot i at bits [i*TAG_W +: TAG_W].
- out_valid  out  1  valid field of the entry presented to the tube input.
- out_tag  out  TAG_W  tag of the presented entry.
- out_data  out  DATA_W  payload of the presented entry.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

## Operation
- Reset (rst low, asynchronous): FIFO empty; out_valid, out_tag, out_data = 0; stall_cnt = 0; in_ready = 0 while rst is low.
- in_ready = rst & (count < FIFO_DEPTH). It is combinational from count only, with no pop-through when full.
- Push: on an edge where in_valid & in_ready, {in_tag, in_data} is written at the tail.
- Hazard (combinational on head):
  - Asserted if head valid and head tag equals tube_tag[i] for any i with tube_valid[i].
  - Also asserted if head tag equals out_tag while out_valid. This covers the entry entering the tube on the next edge.
- Issue: on an edge where head valid and no hazard:
  - Register out_valid <= 1, out_tag/out_data <= head.
  - Pop the head.
- Otherwise, on each edge: out_valid, out_tag and out_data <= 0 (bubble). An entry is presented for exactly one cycle.
- Push and pop on the same edge are both performed; count is unchanged.
- stall_cnt increments on each edge where head valid and hazard. It saturates at 16'hFFFF.
- clr_stats: stall_cnt <= 0. This overrides an increment on the same edge.
- flush (synchronous, highest priority after reset):
  - FIFO emptied.
  - Outputs zeroed.
  - Any push and issue on the same edge is dropped.
  - stall_cnt is unaffected, and so is any stall increment that edge.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Latency: an entry accepted at edge k into an empty FIFO, with no hazard, has out_valid high after edge k+1. It enters tube slot DEPTH-1 at edge k+2.
- Back-to-back issue of distinct tags gives 1 entry/cycle.
- Back-to-back entries with the same tag: the second stalls until the first has left slot 0 of the tube and out no longer holds it.
- Throughput with no hazards: 1 entry/cycle, with in_ready continuously high.
- Full: with count = FIFO_DEPTH, in_ready = 0 in the same cycle. It rises in the cycle after the edge that pops.

## Test plan
- Reset behaviour: assert rst mid-stream with 3 entries buffered and out_valid = 1. The required response is that all outputs go to 0 immediately. After release: in_ready = 1, stall_cnt = 0, and no stale issue occurs.
- Streaming: push tags 1, 2, 3, 4 on consecutive edges with the tube empty. The required response is out_valid high on 4 consecutive cycles with tags 1–4, starting one cycle after the first push, and stall_cnt = 0.
- Same-tag hazard: push tag 7 twice back-to-back with DEPTH = 4. The required response is that the second tag 7 issues only once tube_valid shows no tag-7 slot and out is not tag 7. stall_cnt equals the number of blocked cycles.
- Full/backpressure: hold tube_valid[0] = 1 with tube_tag[0] = 3, then push tag 3 ×5. The required response is in_ready = 0 after 4 pushes and the 5th is not accepted. Release the tube slot: the entries drain and in_ready rises the cycle after the first pop.
- Flush: with 2 entries buffered and a simultaneous push, pulse flush. The required response is count = 0 and out_valid = 0 next cycle, the pushed entry is lost, and stall_cnt is unchanged.
- Saturation and clear: force a permanent hazard for 70000 cycles. The required response is that stall_cnt holds at 65535. Then pulse clr_stats: stall_cnt = 0 next cycle.

Source files
------------

// File: rtl/tube_issue.sv
// Issue stage ahead of the tube tracker: buffers producer entries and
// injects one per cycle when its tag is not already in flight.
module tube_issue #(
    parameter int DEPTH      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 5,
    parameter int DATA_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   clr_stats,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [DEPTH-1:0]       tube_valid,
    input  logic [DEPTH*TAG_W-1:0] tube_tag,
    output logic                   out_valid,
    output logic [TAG_W-1:0]       out_tag,
    output logic [DATA_W-1:0]      out_data,
    output logic [15:0]            stall_cnt
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [TAG_W-1:0]  r_mem_tag  [FIFO_DEPTH];
    logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_out_valid;
    logic [TAG_W-1:0]  r_out_tag;
    logic [DATA_W-1:0] r_out_data;
    logic [15:0]       r_stall_cnt;

    logic              w_head_valid;
    logic [TAG_W-1:0]  w_head_tag;
    logic [DATA_W-1:0] w_head_data;
    logic              w_match;
    logic              w_push;
    logic              w_pop;
    logic              w_stall;

    assign w_head_valid = (r_count != '0);
    assign w_head_tag   = r_mem_tag[r_rptr];
    assign w_head_data  = r_mem_data[r_rptr];

    // The out register counts as an extra tube slot: it enters on the next edge.
    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tube_valid[i] &&
                tube_tag[i*TAG_W +: TAG_W] == w_head_tag) begin
                w_match = 1'b1;
            end
        end
        if (r_out_valid && r_out_tag == w_head_tag) begin
            w_match = 1'b1;
        end
    end

    assign in_ready = rst & (r_count < FULL);
    assign w_push   = in_valid & in_ready;
    assign w_pop    = w_head_valid & ~w_match;
    assign w_stall  = w_head_valid & w_match;

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem_tag[r_wptr]  <= in_tag;
            r_mem_data[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
        end else if (flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_out_valid <= w_pop;
            r_out_tag   <= w_pop ? w_head_tag  : '0;
            r_out_data  <= w_pop ? w_head_data : '0;
        end
    end

    // Flush leaves the statistics alone; clear beats a same-edge increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (clr_stats) begin
            r_stall_cnt <= '0;
        end else if (w_stall && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_tag   = r_out_tag;
    assign out_data  = r_out_data;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_tube_issue.sv
// Directed vector bench for tube_issue with a tiny shifting tube model.
module tb_tube_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        clr_stats;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_tag;
    logic [31:0] in_data;
    logic [3:0]  tube_valid;
    logic [19:0] tube_tag;
    logic        out_valid;
    logic [4:0]  out_tag;
    logic [31:0] out_data;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    tube_issue #(
        .DEPTH(4), .FIFO_DEPTH(4), .TAG_W(5), .DATA_W(32)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_tag(in_tag), .in_data(in_data),
        .tube_valid(tube_valid), .tube_tag(tube_tag),
        .out_valid(out_valid), .out_tag(out_tag),
        .out_data(out_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // ex=0: tube follows the model (shift toward slot 0, out enters slot 3)
    // ex=1: tube driven with tv/tt for this cycle and held there
    typedef struct packed {
        logic        fl;
        logic        clr;
        logic        iv;
        logic [4:0]  tag;
        logic        ex;
        logic [3:0]  tv;
        logic [19:0] tt;
        logic        ov;
        logic [4:0]  ot;
        logic        rdy;
        logic [15:0] st;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] dat(input logic [4:0] t);
        return {16'hD00D, 11'h0, t};
    endfunction

    function automatic vec_t mk(
        input logic fl, input logic clr, input logic iv,
        input logic [4:0] tag, input logic ex,
        input logic [3:0] tv, input logic [19:0] tt,
        input logic ov, input logic [4:0] ot,
        input logic rdy, input logic [15:0] st);
        vec_t v;
        v.fl = fl; v.clr = clr; v.iv = iv; v.tag = tag;
        v.ex = ex; v.tv = tv; v.tt = tt;
        v.ov = ov; v.ot = ot; v.rdy = rdy; v.st = st;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        logic       pv;
        logic [4:0] pt;
        flush     = v.fl;
        clr_stats = v.clr;
        in_valid  = v.iv;
        in_tag    = v.tag;
        in_data   = dat(v.tag);
        if (v.ex) begin
            tube_valid = v.tv;
            tube_tag   = v.tt;
        end
        pv = out_valid;
        pt = out_tag;
        @(posedge clk);
        #1;
        if (!v.ex) begin
            tube_valid = {pv, tube_valid[3:1]};
            tube_tag   = {pt, tube_tag[19:5]};
        end
        chk("out_valid", idx, {31'b0, out_valid}, {31'b0, v.ov});
        chk("out_tag", idx, {27'b0, out_tag}, {27'b0, v.ot});
        chk("out_data", idx, out_data, v.ov ? dat(v.ot) : 32'h0);
        chk("in_ready", idx, {31'b0, in_ready}, {31'b0, v.rdy});
        chk("stall_cnt", idx, {16'b0, stall_cnt}, {16'b0, v.st});
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ov"}, 0, {31'b0, out_valid}, 32'h0);
        chk({nm, "_ot"}, 0, {27'b0, out_tag}, 32'h0);
        chk({nm, "_od"}, 0, out_data, 32'h0);
        chk({nm, "_st"}, 0, {16'b0, stall_cnt}, 32'h0);
        chk({nm, "_rdy"}, 0, {31'b0, in_ready}, 32'h0);
    endtask

    localparam logic [19:0] T20_8 = 20'h00288;
    localparam logic [19:0] T20   = 20'h00280;

    initial begin
        rst = 1'b0; flush = 1'b0; clr_stats = 1'b0;
        in_valid = 1'b0; in_tag = '0; in_data = '0;
        tube_valid = '0; tube_tag = '0;
        #12;
        chk_zero("por");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Mid-stream reset: 3 buffered, out_valid high
        step(mk(0,0,1,5'd8, 1,4'b0011,T20_8, 0,0,1,0), 100);
        step(mk(0,0,1,5'd20,1,4'b0011,T20_8, 0,0,1,1), 101);
        step(mk(0,0,1,5'd20,1,4'b0011,T20_8, 0,0,1,2), 102);
        step(mk(0,0,1,5'd20,1,4'b0010,T20,   1,8,1,2), 103);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("rst");
        in_valid = 1'b0; tube_valid = '0; tube_tag = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(mk(0,0,0,5'd0, 1,4'b0,20'h0, 0,0,1,0), 110 + i);
        end

        // Streaming
        tbl.push_back(mk(0,0,1,5'd1, 0,4'b0,20'h0, 0,0,1,0));
        tbl.push_back(mk(0,0,1,5'd2, 0,4'b0,20'h0, 1,1,1,0));
        tbl.push_back(mk(0,0,1,5'd3, 0,4'b0,20'h0, 1,2,1,0));
        tbl.push_back(mk(0,0,1,5'd4, 0,4'b0,20'h0, 1,3,1,0));
        tbl.push_back(mk(0,0,0,5'd0, 0,4'b0,20'h0, 1,4,1,0));
        tbl.push_back(mk(0,0,0,5'd0, 0,4'b0,20'h0, 0,0,1,0));
        // Same-tag hazard through out register and all 4 slots
        tbl.push_back(mk(0,0,1,5'd7, 0,4'b0,20'h0, 0,0,1,0));
        tbl.push_back(mk(0,0,1,5'd7, 0,4'b0,20'h0, 1,7,1,0));
        tbl.push_back(mk(0,0,0,5'd0, 0,4'b0,20'h0, 0,0,1,1));
        tbl.push_back(mk(0,0,0,5'd0, 0,4'b0,20'h0, 0,0,1,2));
        tbl.push_back(mk(0,0,0,5'd0, 0,4'b0,20'h0, 0,0,1,3));
        tbl.push_back(mk(0,0,0,5'd0, 0,4'b0,20'h0, 0,0,1,4));
        tbl.push_back(mk(0,0,0,5'd0, 0,4'b0,20'h0, 0,0,1,5));
        tbl.push_back(mk(0,0,0,5'd0, 0,4'b0,20'h0, 1,7,1,5));
        tbl.push_back(mk(0,0,0,5'd0, 0,4'b0,20'h0, 0,0,1,5));
        // Full / backpressure with slot 0 holding tag 3
        tbl.push_back(mk(0,0,1,5'd3, 1,4'b0001,20'd3, 0,0,1,5));
        tbl.push_back(mk(0,0,1,5'd3, 1,4'b0001,20'd3, 0,0,1,6));
        tbl.push_back(mk(0,0,1,5'd3, 1,4'b0001,20'd3, 0,0,1,7));
        tbl.push_back(mk(0,0,1,5'd3, 1,4'b0001,20'd3, 0,0,0,8));
        tbl.push_back(mk(0,0,1,5'd3, 1,4'b0001,20'd3, 0,0,0,9));
        tbl.push_back(mk(0,0,0,5'd0, 1,4'b0,20'h0, 1,3,1,9));
        tbl.push_back(mk(0,0,0,5'd0, 1,4'b0,20'h0, 0,0,1,10));
        tbl.push_back(mk(0,0,0,5'd0, 1,4'b0,20'h0, 1,3,1,10));
        tbl.push_back(mk(0,0,0,5'd0, 1,4'b0,20'h0, 0,0,1,11));
        tbl.push_back(mk(0,0,0,5'd0, 1,4'b0,20'h0, 1,3,1,11));
        tbl.push_back(mk(0,0,0,5'd0, 1,4'b0,20'h0, 0,0,1,12));
        tbl.push_back(mk(0,0,0,5'd0, 1,4'b0,20'h0, 1,3,1,12));
        tbl.push_back(mk(0,0,0,5'd0, 1,4'b0,20'h0, 0,0,1,12));
        // Flush with 2 buffered and a simultaneous push
        tbl.push_back(mk(0,0,1,5'd9, 1,4'b0001,20'd9, 0,0,1,12));
        tbl.push_back(mk(0,0,1,5'd9, 1,4'b0001,20'd9, 0,0,1,13));
        tbl.push_back(mk(1,0,1,5'd5, 1,4'b0,20'h0, 0,0,1,13));
        tbl.push_back(mk(0,0,0,5'd0, 1,4'b0,20'h0, 0,0,1,13));
        tbl.push_back(mk(0,0,0,5'd0, 1,4'b0,20'h0, 0,0,1,13));
        // clr_stats, including against a same-edge increment
        tbl.push_back(mk(0,1,0,5'd0, 1,4'b0,20'h0, 0,0,1,0));
        tbl.push_back(mk(0,0,1,5'd6, 1,4'b0001,20'd6, 0,0,1,0));
        tbl.push_back(mk(0,0,0,5'd0, 1,4'b0001,20'd6, 0,0,1,1));
        tbl.push_back(mk(0,1,0,5'd0, 1,4'b0001,20'd6, 0,0,1,0));
        tbl.push_back(mk(0,0,0,5'd0, 1,4'b0000,20'd6, 1,6,1,0));
        tbl.push_back(mk(0,0,0,5'd0, 1,4'b0000,20'd6, 0,0,1,0));

        foreach (tbl[i]) begin
            step(tbl[i], i);
        end

        // Saturation under a permanent hazard
        step(mk(0,0,1,5'd1, 1,4'b0001,20'd1, 0,0,1,0), 200);
        step(mk(0,0,0,5'd0, 1,4'b0001,20'd1, 0,0,1,1), 201);
        repeat (70000) @(posedge clk);
        #1;
        chk("sat", 202, {16'b0, stall_cnt}, 32'h0000FFFF);
        step(mk(0,0,0,5'd0, 1,4'b0001,20'd1, 0,0,1,16'hFFFF), 203);
        step(mk(0,1,0,5'd0, 1,4'b0001,20'd1, 0,0,1,0), 204);
        step(mk(1,0,0,5'd0, 1,4'b0000,20'd0, 0,0,1,0), 205);
        step(mk(0,0,0,5'd0, 1,4'b0000,20'd0, 0,0,1,0), 206);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
